// File: rtl/scope_sweep_ctrl_if.sv
// Signal bundle between the sweep sequencer and the ADC front end, sample RAM write port and column drawer.
// master = surrounding datapath/testbench, slave = scope_sweep_ctrl.
interface scope_sweep_ctrl_if #(
    parameter int ADDR_W   = 8,
    parameter int SAMPLE_W = 8
);
    logic                run;
    logic                single;
    logic [1:0]          time_division;
    logic [SAMPLE_W-1:0] trig_level;
    logic                trig_rising;
    logic                adc_valid;
    logic [SAMPLE_W-1:0] adc_sample;
    logic                frame_start;
    logic                draw_finished;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                draw_enable;
    logic                draw_reset;
    logic                triggered;
    logic [2:0]          state_o;

    modport master (
        output run, single, time_division, trig_level, trig_rising,
               adc_valid, adc_sample, frame_start, draw_finished,
        input  wr_en, wr_addr, wr_data, draw_enable, draw_reset, triggered, state_o
    );

    modport slave (
        input  run, single, time_division, trig_level, trig_rising,
               adc_valid, adc_sample, frame_start, draw_finished,
        output wr_en, wr_addr, wr_data, draw_enable, draw_reset, triggered, state_o
    );
endinterface

// File: rtl/scope_sweep_ctrl.sv
// Trace sequencer: arm on trigger, capture decimated samples, draw one frame, hold off, re-arm.
// Latency: writes/triggered registered one cycle after the accepted adc_valid; no backpressure (ADC strobe is never stalled).
// SCOPE_AUTO_TRIGGER_EN adds an ARM timeout (AUTO_TIMEOUT valid samples) that forces a trigger.
module scope_sweep_ctrl #(
    parameter int COLS     = 160,
    parameter int ADDR_W   = 8,
    parameter int SAMPLE_W = 8,
    parameter int HOLDOFF  = 2
`ifdef SCOPE_AUTO_TRIGGER_EN
    ,
    parameter int AUTO_TIMEOUT = 4096
`endif
) (
    input logic               i_clk,
    input logic               i_reset,
    scope_sweep_ctrl_if.slave io_bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        CAPTURE    = 3'd2,
        WAIT_FRAME = 3'd3,
        DRAW       = 3'd4,
        HOLD       = 3'd5
    } state_t;

    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [ADDR_W-1:0] PRE_LAST_ADDR = ADDR_W'(COLS - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(HOLDOFF);

    state_t              r_state;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [SAMPLE_W-1:0] r_wr_data;
    logic                r_draw_enable;
    logic                r_draw_reset;
    logic                r_triggered;
    logic                r_single_pending;
    logic                r_single_shot;
    logic                r_prev_valid;
    logic [SAMPLE_W-1:0] r_prev_sample;
    logic [2:0]          r_dec_cnt;
    logic [1:0]          r_td;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic                w_rise;
    logic                w_fall;
    logic                w_force;
    logic                w_trig;
    logic                w_arm_req;
    logic [2:0]          w_dec_last;

    assign w_rise = (r_prev_sample < io_bus.trig_level) && (io_bus.adc_sample >= io_bus.trig_level);
    assign w_fall = (r_prev_sample > io_bus.trig_level) && (io_bus.adc_sample <= io_bus.trig_level);
    assign w_trig = (r_state == ARM) && io_bus.adc_valid &&
                    ((r_prev_valid && (io_bus.trig_rising ? w_rise : w_fall)) || w_force);
    assign w_arm_req = io_bus.run || r_single_pending;

    always_comb begin
        w_dec_last = 3'd0;
        case (r_td)
            2'd0:    w_dec_last = 3'd0;
            2'd1:    w_dec_last = 3'd1;
            2'd2:    w_dec_last = 3'd3;
            default: w_dec_last = 3'd7;
        endcase
    end

`ifdef SCOPE_AUTO_TRIGGER_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [AUTO_W-1:0] r_auto_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || (r_state != ARM) || w_trig) begin
            r_auto_cnt <= '0;
        end else if (io_bus.adc_valid) begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    // Timeout reached: the next valid sample triggers regardless of level.
    assign w_force = (r_auto_cnt == AUTO_W'(AUTO_TIMEOUT));
`else
    assign w_force = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_wr_en          <= 1'b0;
            r_wr_addr        <= '0;
            r_wr_data        <= '0;
            r_draw_enable    <= 1'b0;
            r_draw_reset     <= 1'b1;
            r_triggered      <= 1'b0;
            r_single_pending <= 1'b0;
            r_single_shot    <= 1'b0;
            r_prev_valid     <= 1'b0;
            r_prev_sample    <= '0;
            r_dec_cnt        <= '0;
            r_td             <= '0;
            r_hold_cnt       <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_triggered <= 1'b0;
            if (io_bus.single) begin
                r_single_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_arm_req) begin
                        r_state          <= ARM;
                        r_prev_valid     <= 1'b0;
                        r_single_shot    <= !io_bus.run;
                        r_single_pending <= io_bus.single;
                    end
                end
                ARM: begin
                    if (w_trig) begin
                        r_state     <= CAPTURE;
                        r_triggered <= 1'b1;
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= '0;
                        r_wr_data   <= io_bus.adc_sample;
                        r_dec_cnt   <= '0;
                        r_td        <= io_bus.time_division;
                    end else begin
                        if (io_bus.adc_valid) begin
                            r_prev_sample <= io_bus.adc_sample;
                            r_prev_valid  <= 1'b1;
                        end
                        if (!io_bus.run && !r_single_pending && !r_single_shot) begin
                            r_state <= IDLE;
                        end
                    end
                end
                CAPTURE: begin
                    if (io_bus.adc_valid) begin
                        if (r_dec_cnt == w_dec_last) begin
                            r_dec_cnt <= '0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_wr_addr + 1'b1;
                            r_wr_data <= io_bus.adc_sample;
                            if (r_wr_addr == PRE_LAST_ADDR) begin
                                r_state <= WAIT_FRAME;
                            end
                        end else begin
                            r_dec_cnt <= r_dec_cnt + 1'b1;
                        end
                    end
                end
                WAIT_FRAME: begin
                    r_wr_addr <= '0;
                    // r_wr_en high means the final write is on the bus this cycle; that frame is too late.
                    if (io_bus.frame_start && !r_wr_en) begin
                        r_state       <= DRAW;
                        r_draw_enable <= 1'b1;
                        r_draw_reset  <= 1'b0;
                    end
                end
                DRAW: begin
                    if (io_bus.draw_finished) begin
                        r_state       <= HOLD;
                        r_hold_cnt    <= '0;
                        r_draw_enable <= 1'b0;
                        r_draw_reset  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        if (!r_single_shot && w_arm_req) begin
                            r_state          <= ARM;
                            r_prev_valid     <= 1'b0;
                            r_single_shot    <= !io_bus.run;
                            r_single_pending <= io_bus.single;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (io_bus.frame_start) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.wr_en       = r_wr_en;
    assign io_bus.wr_addr     = r_wr_addr;
    assign io_bus.wr_data     = r_wr_data;
    assign io_bus.draw_enable = r_draw_enable;
    assign io_bus.draw_reset  = r_draw_reset;
    assign io_bus.triggered   = r_triggered;
    assign io_bus.state_o     = r_state;
endmodule

// File: tb/tb_scope_sweep_ctrl.sv
// Directed bench for scope_sweep_ctrl: trigger modes, decimated capture, draw/holdoff sequencing, single-shot, reset abort.
module tb_scope_sweep_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;
    logic addr_over = 1'b0;
    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    scope_sweep_ctrl_if #(.ADDR_W(8), .SAMPLE_W(8)) bus ();

    scope_sweep_ctrl #(
        .COLS(160), .ADDR_W(8), .SAMPLE_W(8), .HOLDOFF(2)
`ifdef SCOPE_AUTO_TRIGGER_EN
        , .AUTO_TIMEOUT(16)
`endif
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .io_bus(bus)
    );

    // Sample RAM model fed from the write port.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] = bus.wr_data;
            wr_count++;
            if (bus.wr_addr > 8'd159) addr_over = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adc(input logic [7:0] s);
        bus.adc_valid  = 1'b1;
        bus.adc_sample = s;
        tick();
        bus.adc_valid  = 1'b0;
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic pulse_fin();
        bus.draw_finished = 1'b1;
        tick();
        bus.draw_finished = 1'b0;
    endtask

    initial begin
        int base;
        int trig_seen;
        bus.run = 1'b0; bus.single = 1'b0; bus.time_division = 2'd0;
        bus.trig_level = 8'd128; bus.trig_rising = 1'b1;
        bus.adc_valid = 1'b0; bus.adc_sample = 8'd0;
        bus.frame_start = 1'b0; bus.draw_finished = 1'b0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        check("rst_state", 32'(bus.state_o), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_draw_reset", 32'(bus.draw_reset), 1);
        check("rst_draw_enable", 32'(bus.draw_enable), 0);
        check("rst_triggered", 32'(bus.triggered), 0);

        // Rising trigger, no decimation, full pass through draw and holdoff
        base = wr_count;
        bus.run = 1'b1;
        tick();
        check("a_arm", 32'(bus.state_o), 1);
        adc(8'd100);
        check("a_no_trig0", 32'(bus.triggered), 0);
        adc(8'd120);
        check("a_no_trig1", 32'(bus.triggered), 0);
        adc(8'd130);
        check("a_trig", 32'(bus.triggered), 1);
        check("a_wr_en0", 32'(bus.wr_en), 1);
        check("a_addr0", 32'(bus.wr_addr), 0);
        check("a_data0", 32'(bus.wr_data), 130);
        check("a_capture", 32'(bus.state_o), 2);
        tick();
        check("a_trig_pulse", 32'(bus.triggered), 0);
        for (int i = 1; i <= 159; i++) begin
            adc(8'(i));
            check("a_addr", 32'(bus.wr_addr), 32'(i));
        end
        check("a_last_en", 32'(bus.wr_en), 1);
        check("a_wait_frame", 32'(bus.state_o), 3);
        pulse_fs();
        check("a_fs_same_cycle_ignored", 32'(bus.state_o), 3);
        check("a_addr_back0", 32'(bus.wr_addr), 0);
        pulse_fs();
        check("a_draw", 32'(bus.state_o), 4);
        check("a_draw_en", 32'(bus.draw_enable), 1);
        check("a_draw_rst", 32'(bus.draw_reset), 0);
        repeat (3) tick();
        check("a_draw_stay", 32'(bus.state_o), 4);
        pulse_fin();
        check("a_hold", 32'(bus.state_o), 5);
        check("a_hold_draw_en", 32'(bus.draw_enable), 0);
        check("a_hold_draw_rst", 32'(bus.draw_reset), 1);
        pulse_fs();
        check("a_hold1", 32'(bus.state_o), 5);
        pulse_fs();
        tick();
        check("a_rearm", 32'(bus.state_o), 1);
        check("a_writes", 32'(wr_count - base), 160);
        check("a_mem0", 32'(mem[0]), 130);
        check("a_mem159", 32'(mem[159]), 159);

        // Reset mid-capture at wr_addr 37
        adc(8'd10);
        adc(8'd200);
        check("r_trig", 32'(bus.triggered), 1);
        for (int i = 0; i < 37; i++) adc(8'd5);
        check("r_addr37", 32'(bus.wr_addr), 37);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        bus.run = 1'b0;
        check("r_state", 32'(bus.state_o), 0);
        check("r_wr_en", 32'(bus.wr_en), 0);
        check("r_addr", 32'(bus.wr_addr), 0);
        check("r_draw_reset", 32'(bus.draw_reset), 1);
        check("r_draw_enable", 32'(bus.draw_enable), 0);
        tick();
        check("r_idle_after", 32'(bus.state_o), 0);

        // Falling trigger, divide by 4, time_division changed mid-capture
        base = wr_count;
        addr_over = 1'b0;
        bus.run = 1'b1; bus.time_division = 2'd2;
        bus.trig_rising = 1'b0; bus.trig_level = 8'd50;
        tick();
        adc(8'd60);
        check("f_no_trig", 32'(bus.triggered), 0);
        adc(8'd40);
        check("f_trig", 32'(bus.triggered), 1);
        check("f_data0", 32'(bus.wr_data), 40);
        bus.time_division = 2'd0;
        for (int i = 0; i <= 1000; i++) adc(8'(i));
        check("f_writes", 32'(wr_count - base), 160);
        check("f_addr_over", 32'(addr_over), 0);
        check("f_mem0", 32'(mem[0]), 40);
        check("f_mem1", 32'(mem[1]), 3);
        check("f_mem2", 32'(mem[2]), 7);
        check("f_mem159", 32'(mem[159]), 123);
        check("f_wait_frame", 32'(bus.state_o), 3);
        bus.run = 1'b0;
        pulse_fs();
        check("f_draw", 32'(bus.state_o), 4);
        pulse_fin();
        pulse_fs();
        pulse_fs();
        tick();
        check("f_idle", 32'(bus.state_o), 0);

        // Single-shot acquisition with run low
        base = wr_count;
        bus.time_division = 2'd0; bus.trig_rising = 1'b1; bus.trig_level = 8'd128;
        bus.single = 1'b1;
        tick();
        bus.single = 1'b0;
        check("s_pending_idle", 32'(bus.state_o), 0);
        tick();
        check("s_arm", 32'(bus.state_o), 1);
        repeat (4) tick();
        check("s_arm_stays", 32'(bus.state_o), 1);
        adc(8'd100);
        adc(8'd150);
        check("s_trig", 32'(bus.triggered), 1);
        for (int i = 1; i <= 159; i++) adc(8'd77);
        check("s_wait_frame", 32'(bus.state_o), 3);
        tick();
        pulse_fs();
        check("s_draw", 32'(bus.state_o), 4);
        pulse_fin();
        pulse_fs();
        pulse_fs();
        tick();
        check("s_idle", 32'(bus.state_o), 0);
        repeat (20) tick();
        check("s_no_rearm", 32'(bus.state_o), 0);
        check("s_writes", 32'(wr_count - base), 160);

        // First valid sample above level must not trigger
        bus.run = 1'b1;
        tick();
        check("t_arm", 32'(bus.state_o), 1);
        adc(8'd200);
        check("t_first_no_trig", 32'(bus.triggered), 0);
        trig_seen = 0;
`ifdef SCOPE_AUTO_TRIGGER_EN
        for (int i = 2; i <= 16; i++) begin
            adc(8'd200);
            if (bus.triggered) trig_seen++;
        end
        check("t_no_early_auto", 32'(trig_seen), 0);
        adc(8'd200);
        check("t_auto_trig", 32'(bus.triggered), 1);
        check("t_auto_capture", 32'(bus.state_o), 2);
        check("t_auto_data", 32'(bus.wr_data), 200);
`else
        for (int i = 0; i < 30; i++) begin
            adc(8'd200);
            if (bus.triggered) trig_seen++;
        end
        check("t_flat_no_trig", 32'(trig_seen), 0);
        check("t_still_arm", 32'(bus.state_o), 1);
`endif
        bus.run = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scope_sweep_ctrl.md
Name: scope_sweep_ctrl

Overview:
Sequencer for the oscilloscope trace path. It arms on a trigger condition and captures decimated ADC samples into the column sample buffer. It then runs the column-sweep drawer for one frame-aligned pass and applies a frame holdoff before re-arming. It sits between the ADC front end, the dual-port sample RAM write port and the column drawer's enable/reset/finished handshake.

Parameters:
COLS, 160, columns per trace; capture length and last write address is COLS-1
ADDR_W, 8, sample buffer address width
SAMPLE_W, 8, sample/level width
HOLDOFF, 2, frame_start pulses to wait after a draw before re-arming (0 = none)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
run  in  1  level; continuous acquisition while high
single  in  1  one-cycle pulse; request exactly one acquisition
time_division  in  2  decimation select; D = 1 << time_division (1,2,4,8)
trig_level  in  SAMPLE_W  trigger threshold, unsigned
trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge
adc_valid  in  1  sample strobe
adc_sample  in  SAMPLE_W  unsigned sample
frame_start  in  1  one-cycle pulse at start of vertical blank
draw_finished  in  1  drawer reports last column done
wr_en  out  1  sample buffer write strobe
wr_addr  out  ADDR_W  sample buffer write address
wr_data  out  SAMPLE_W  sample buffer write data
draw_enable  out  1  drawer advance enable
draw_reset  out  1  holds drawer column counter at 0
triggered  out  1  one-cycle pulse on trigger detection
state_o  out  3  current state encoding (debug)

Behaviour:
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, draw_enable 0, draw_reset 1, triggered 0, single_pending 0, all counters 0. Reset mid-operation aborts immediately to these values; buffer contents are not cleared.
- State encodings: IDLE=0, ARM=1, CAPTURE=2, WAIT_FRAME=3, DRAW=4, HOLD=5.
- draw_reset=1 in every state except DRAW. draw_enable=1 only in DRAW.
- single sets single_pending in any state; single_pending clears on the entry to ARM it causes.
- IDLE: go to ARM next cycle if run=1 or single_pending=1.
- ARM:
  - On entry, prev_valid=0.
  - Each adc_valid updates prev_sample and sets prev_valid. The first valid sample after entry never triggers.
  - Trigger when prev_valid and adc_valid. Rising: prev<trig_level and adc_sample>=trig_level. Falling: prev>trig_level and adc_sample<=trig_level.
  - On trigger: triggered=1 for one cycle. The triggering sample is written at address 0 with wr_en the cycle after detection. dec_cnt=0. Go to CAPTURE.
  - run=0 with no single_pending and not a single-shot acquisition: return to IDLE.
- CAPTURE:
  - Counts adc_valid pulses modulo D; a sample is written when dec_cnt reaches D-1. wr_addr increments by 1 per write.
  - time_division is sampled at the trigger and held constant for the whole capture.
  - Write latency: wr_en/wr_addr/wr_data registered, asserted the cycle after the accepted adc_valid.
  - After the write to COLS-1, go to WAIT_FRAME. wr_addr then returns to 0.
  - run deassertion does not abort a capture.
- WAIT_FRAME: frame_start goes to DRAW on the next cycle. A frame_start in the same cycle as the final write is ignored; wait for the next one.
- DRAW: draw_finished goes to HOLD. If HOLDOFF=0, HOLD exits on the next cycle.
- HOLD:
  - Count frame_start pulses.
  - When the count reaches HOLDOFF: go to ARM if run=1 or single_pending=1, else IDLE.
  - A single-shot acquisition (started with run=0) always goes to IDLE.
- No overflow: wr_addr never exceeds COLS-1. The decimation counter is 3 bits wide.

Optional Feature:
SCOPE_AUTO_TRIGGER_EN
- Defined: parameter AUTO_TIMEOUT (default 4096) is added. In ARM, a counter counts adc_valid pulses. If it reaches AUTO_TIMEOUT without a trigger, a forced trigger occurs on the next valid sample: triggered pulses, capture proceeds normally, and the counter is cleared.
- Undefined: ARM waits indefinitely. No timeout counter logic exists.

Test Plan:
- reset held 3 cycles mid-CAPTURE (wr_addr=37) -> next cycle state_o=0, wr_en=0, wr_addr=0, draw_reset=1, draw_enable=0.
- run=1, rising, trig_level=128, samples 100,120,130 -> triggered after 130. 130 written at addr 0. With time_division=0, the next 159 samples are written to addr 1..159, then state_o=3.
- time_division=2, falling, trig_level=50, samples 60,40 then ramp 0..1000 -> addr 0=40. Writes occur every 4th valid sample, 160 writes total. wr_addr never exceeds 159.
- Capture complete, frame_start pulse -> draw_enable=1, draw_reset=0. draw_finished -> HOLD. After 2 frame_start pulses with run=1 -> state_o=1.
- run=0, single pulse -> exactly one capture and draw, then IDLE. No second ARM without a new single pulse.
- First valid sample in ARM already >= level (200 vs 128) -> no trigger. With SCOPE_AUTO_TRIGGER_EN and AUTO_TIMEOUT=16, a flat input of 200 forces a trigger on the 17th valid sample.
